// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity encodings and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_OVERSAMPLE = 8;

    localparam logic UART_PARITY_EVEN = 1'b1;
    localparam logic UART_PARITY_ODD  = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit sample counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX_IN,
    input  logic idle,
    input  logic active,
    output logic rx_s,
    output logic bit_val,
    output logic bit_strobe,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;

    assign rx_s = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    // The IDLE cycle that first sees rx_s low is count 0 of the start bit,
    // so the counter leaves IDLE already at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (idle) begin
            r_cnt <= rx_s ? '0 : CW'(1);
        end else if (active) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (active) begin
            if (r_cnt == C_S0) r_s0 <= rx_s;
            if (r_cnt == C_S1) r_s1 <= rx_s;
        end
    end

    assign bit_val    = maj3(r_s0, r_s1, rx_s);
    assign bit_strobe = active && (r_cnt == C_DEC);
    assign bit_end    = active && (r_cnt == C_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with one-cycle valid and error pulses.
// Optional parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_rx_state_t        r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_dv;
    logic                  r_se;
    logic                  w_rx_s;
    logic                  w_bit_val;
    logic                  w_bit_strobe;
    logic                  w_bit_end;
    logic                  w_idle;
    logic                  w_active;

`ifdef UART_RX_PARITY_EN
    logic r_pen;
    logic r_ptype;
    logic r_par_bad;
    logic r_pe;
    logic w_par_exp;

    assign w_par_exp    = (^r_shift) ^ ~r_ptype;
    assign parity_error = r_pe;
`else
    logic w_unused_parity;

    assign w_unused_parity = parity_enable ^ parity_type;
    assign parity_error    = 1'b0;
`endif

    assign w_idle     = (r_state == RX_IDLE);
    assign w_active   = (r_state == RX_START) || (r_state == RX_DATA) ||
                        (r_state == RX_PARITY) || (r_state == RX_STOP);
    assign busy       = !w_idle;
    assign P_DATA     = r_data;
    assign Data_Valid = r_dv;
    assign stop_error = r_se;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX_IN     (RX_IN),
        .idle      (w_idle),
        .active    (w_active),
        .rx_s      (w_rx_s),
        .bit_val   (w_bit_val),
        .bit_strobe(w_bit_strobe),
        .bit_end   (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_shift   <= '0;
            r_data    <= '0;
            r_bitcnt  <= '0;
            r_dv      <= 1'b0;
            r_se      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pen     <= 1'b0;
            r_ptype   <= 1'b0;
            r_par_bad <= 1'b0;
            r_pe      <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_se <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= RX_START;
                        r_bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_pen     <= parity_enable;
                        r_ptype   <= parity_type;
                        r_par_bad <= 1'b0;
`endif
                    end
                end
                RX_START: begin
                    if (w_bit_strobe && w_bit_val) begin
                        r_state <= RX_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_bit_strobe) begin
                        r_shift <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= r_pen ? RX_PARITY : RX_STOP;
`else
                            r_state <= RX_STOP;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (w_bit_strobe && (w_bit_val != w_par_exp)) begin
                        r_par_bad <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_state <= RX_STOP;
                    end
                end
`endif
                // Leave at the decision point so a start bit right after stop is caught.
                RX_STOP: begin
                    if (w_bit_strobe) begin
                        r_state <= RX_IDLE;
                        if (!w_bit_val) begin
                            r_se    <= 1'b1;
                            r_state <= RX_WAIT_IDLE;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (r_par_bad) begin
                            r_pe <= 1'b1;
                        end
`endif
                        else begin
                            r_data <= r_shift;
                            r_dv   <= 1'b1;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (w_rx_s) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; parity scenarios apply when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int OS = 8;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          RX_IN         = 1'b1;
    logic          parity_enable = 1'b0;
    logic          parity_type   = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    uart_rx #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_IN        (RX_IN),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    int multi_cnt = 0;
    int busy_cnt = 0;
    int dv_cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int st;
    logic [DW-1:0] last_good;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Data_Valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (parity_error) pe_cnt = pe_cnt + 1;
        if (stop_error) se_cnt = se_cnt + 1;
        if ((int'(Data_Valid) + int'(parity_error) + int'(stop_error)) > 1) multi_cnt = multi_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_mon();
        dv_cnt   = 0;
        pe_cnt   = 0;
        se_cnt   = 0;
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit has_par, input logic pbit,
                        input logic sbit, output int start);
        start = cyc;
        RX_IN = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            repeat (OS) @(negedge clk);
        end
        if (has_par) begin
            RX_IN = pbit;
            repeat (OS) @(negedge clk);
        end
        RX_IN = sbit;
        repeat (OS) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_dv", Data_Valid, 0);
        chk("rst_pe", parity_error, 0);
        chk("rst_se", stop_error, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(4);

        // no parity, 0xAA
        clr_mon();
        send(8'hAA, 0, 1'b0, 1'b1, st);
        idle(12);
        chk("aa_dv_cnt", dv_cnt, 1);
        chk("aa_pdata", P_DATA, 32'hAA);
        chk("aa_pe", pe_cnt, 0);
        chk("aa_se", se_cnt, 0);
        chk("aa_latency", dv_cyc - st, 80);
        chk("aa_busy_len", busy_cnt, 77);
        chk("aa_busy_end", busy, 0);
        last_good = 8'hAA;

`ifdef UART_RX_PARITY_EN
        parity_enable = 1'b1;
        parity_type   = UART_PARITY_EVEN;
        clr_mon();
        send(8'hA5, 1, 1'b0, 1'b1, st);
        idle(12);
        chk("even_ok_dv", dv_cnt, 1);
        chk("even_ok_pdata", P_DATA, 32'hA5);
        chk("even_ok_pe", pe_cnt, 0);
        chk("even_latency", dv_cyc - st, 88);
        chk("even_busy_len", busy_cnt, 85);

        clr_mon();
        send(8'hA5, 1, 1'b1, 1'b1, st);
        idle(12);
        chk("even_bad_pe", pe_cnt, 1);
        chk("even_bad_dv", dv_cnt, 0);
        chk("even_bad_pdata", P_DATA, 32'hA5);

        clr_mon();
        send(8'h5A, 1, 1'b1, 1'b1, st);
        idle(12);
        chk("even_bad2_pe", pe_cnt, 1);
        chk("even_bad2_pdata", P_DATA, 32'hA5);

        parity_type = UART_PARITY_ODD;
        clr_mon();
        send(8'h3C, 1, 1'b1, 1'b1, st);
        idle(12);
        chk("odd_dv", dv_cnt, 1);
        chk("odd_pdata", P_DATA, 32'h3C);
        chk("odd_pe", pe_cnt, 0);
        chk("odd_se", se_cnt, 0);
        last_good = 8'h3C;
`else
        parity_enable = 1'b1;
        parity_type   = UART_PARITY_EVEN;
        clr_mon();
        send(8'hA5, 0, 1'b0, 1'b1, st);
        idle(12);
        chk("nopar_dv", dv_cnt, 1);
        chk("nopar_pdata", P_DATA, 32'hA5);
        chk("nopar_pe", pe_cnt, 0);
        chk("nopar_latency", dv_cyc - st, 80);
        last_good = 8'hA5;
`endif
        parity_enable = 1'b0;

        // 2-cycle glitch on idle line
        clr_mon();
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        chk("glitch_busy_short", (busy_cnt > 0) && (busy_cnt < OS), 1);
        chk("glitch_flags", dv_cnt + pe_cnt + se_cnt, 0);
        chk("glitch_idle", busy, 0);

        // bad stop bit, then line held low
        clr_mon();
        send(8'h55, 0, 1'b0, 1'b0, st);
        RX_IN = 1'b0;
        repeat (40) @(negedge clk);
        chk("break_busy", busy, 1);
        idle(12);
        chk("stop_se", se_cnt, 1);
        chk("stop_dv", dv_cnt, 0);
        chk("stop_pdata", P_DATA, 32'(last_good));
        chk("stop_idle", busy, 0);

        clr_mon();
        send(8'h0F, 0, 1'b0, 1'b1, st);
        idle(12);
        chk("after_break_dv", dv_cnt, 1);
        chk("after_break_pdata", P_DATA, 32'h0F);
        chk("after_break_se", se_cnt, 0);

        // reset during data bit 3 of 0xFF
        clr_mon();
        RX_IN = 1'b0;
        repeat (OS) @(negedge clk);
        RX_IN = 1'b1;
        repeat (3 * OS + 3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_pdata", P_DATA, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dv", Data_Valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        chk("midrst_no_pulse", dv_cnt + pe_cnt + se_cnt, 0);

        clr_mon();
        send(8'h81, 0, 1'b0, 1'b1, st);
        idle(12);
        chk("post_rst_dv", dv_cnt, 1);
        chk("post_rst_pdata", P_DATA, 32'h81);
        chk("post_rst_latency", dv_cyc - st, 80);

        chk("one_pulse_at_a_time", multi_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver; the receive-side counterpart of `UART_TX`. It takes the asynchronous serial line, oversamples it and recovers start/data/parity/stop framing, then presents each byte as a one-cycle `Data_Valid` pulse with parity and framing error flags. It sits between the pad-side RX line and the system register/FIFO interface. Its frame format matches `UART_TX` exactly: idle-high, one start bit, `DATA_WIDTH` data bits LSB first, optional parity bit, one stop bit.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame.
- `OVERSAMPLE`, 8, clk cycles per serial bit; must be even and ≥ 4.
- `clk`  input  1  system clock; one clock domain.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `RX_IN`  input  1  asynchronous serial line; idle high.
- `parity_enable`  input  1  1 means a parity bit follows the data bits.
- `parity_type`  input  1  1 means even parity; 0 means odd parity (same encoding as TX).
- `P_DATA`  output  DATA_WIDTH  last correctly received word.
- `Data_Valid`  output  1  one-cycle pulse when `P_DATA` is updated.
- `parity_error`  output  1  one-cycle pulse when the parity check fails.
- `stop_error`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  output  1  high while a frame is in progress (every state except IDLE).

## Operation
- `RX_IN` passes through a 2-flop synchronizer. All logic below uses the synchronized signal `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE**
  - On the first cycle where `rx_s` is 0: clear the sample counter and go to START.
- **Bit sampling (all states except IDLE and WAIT_IDLE)**
  - The sample counter runs from 0 to `OVERSAMPLE`-1 within each bit.
  - `rx_s` is sampled at counts `OVERSAMPLE/2`-1, `OVERSAMPLE/2` and `OVERSAMPLE/2`+1.
  - The bit value is the 2-of-3 majority of those samples, decided at count `OVERSAMPLE/2`+1.
- **START**
  - Majority 1 means a glitch: return to IDLE with no flags.
  - Otherwise move to DATA at counter wrap.
- **DATA**
  - Shift the decided bit in LSB first.
  - After `DATA_WIDTH` bits, go to PARITY if `parity_enable`, otherwise go to STOP.
- **PARITY**
  - Expected bit is the XOR of the data bits, inverted when `parity_type`=0 (odd).
  - A mismatch latches an internal `par_bad` flag.
- **STOP**, at the decision count:
  - Bit 0: pulse `stop_error`, go to WAIT_IDLE. `P_DATA` is not updated.
  - Bit 1 with `par_bad` set: pulse `parity_error`, go to IDLE. `P_DATA` is not updated.
  - Bit 1 with `par_bad` clear: load `P_DATA`, pulse `Data_Valid`, go to IDLE.
  - STOP exits at the decision count, not at counter wrap, so back-to-back frames are not missed.
- **WAIT_IDLE**: stay until `rx_s` is 1. This handles a break or a stuck-low line.
- `parity_enable` and `parity_type` are captured on leaving IDLE. Changes during a frame have no effect until the next frame.

## Timing
- Reset values: `P_DATA`=0, `Data_Valid`=0, `parity_error`=0, `stop_error`=0, `busy`=0, state IDLE, synchronizer flops at 1.
- Synchronizer latency: 2 cycles from `RX_IN` to `rx_s`.
- `Data_Valid`, `parity_error` and `stop_error` are registered. They assert the cycle after the stop-bit decision and last exactly 1 cycle.
- At most one of the three pulses is high in any cycle.
- Frame latency: `Data_Valid` rises (1 + `DATA_WIDTH` + PE) × `OVERSAMPLE` + `OVERSAMPLE/2` + 2 cycles after the first low `rx_s`, where PE = `parity_enable`.
- `P_DATA` holds its value until the next good frame.
- Reset asserted mid-frame: asynchronous return to IDLE. All outputs go to reset values and no pulse is generated.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined**: PARITY state and `parity_error` behave as described above.
- **Undefined**:
  - The PARITY state and parity logic are not built; `parity_enable` and `parity_type` are ignored.
  - DATA always goes directly to STOP.
  - `parity_error` is tied to 0.
  - The ports remain present.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - constants `UART_PARITY_EVEN`=1 and `UART_PARITY_ODD`=0;
  - the default `DATA_WIDTH` and `OVERSAMPLE` values.
- One sub-module, `uart_rx_sampler`, contains the synchronizer, the sample counter and the 3-sample majority vote. It outputs `bit_val`, `bit_strobe` (decision count) and `bit_end` (counter wrap).
- The FSM, shift register and parity/stop checks stay in `uart_rx`.

## Test plan
- No parity, send 0xAA (`OVERSAMPLE`=8) → `Data_Valid` pulses once, `P_DATA`=0xAA, both error flags stay 0, `busy` falls after the stop decision.
- Even parity, send 0xA5 with parity bit 0 → `P_DATA`=0xA5, `Data_Valid` pulses. Repeat with parity bit 1 → `parity_error` pulses and `P_DATA` stays 0xA5.
- Odd parity, send 0x3C with parity bit 1 → `P_DATA`=0x3C, `Data_Valid` pulses, no errors.
- Drive a 2-cycle low glitch on idle `RX_IN` → no flags, FSM back in IDLE, `busy` high for fewer than `OVERSAMPLE` cycles.
- Send 0x55 with stop bit 0, then hold the line low for 40 cycles → one `stop_error` pulse, no `Data_Valid`. A following 0x0F frame is received correctly once the line returns high.
- Assert `rst_n`=0 during data bit 3 of 0xFF → all outputs reset immediately. A subsequent 0x81 frame is received correctly.
